exec_alu_mc: RTL and testbench

- Multi-cycle execute unit directly downstream of the operand-B select mux.
- Consumes operand A (register read data) and operand B (the mux output: register data or immediate).
- Performs the decoded ALU operation and returns a 32-bit result with flags to the write-back stage.
- Uses a valid/ready handshake on both sides.
- Simple ops finish in one cycle; shifts and multiply iterate internally.

---
 rtl/exec_pkg.sv | 24 ++
 rtl/exec_seq_core.sv | 70 +++++++
 rtl/exec_alu_mc.sv | 127 ++++++++++++
 tb/tb_exec_alu_mc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared op codes, FSM encodings and width defaults for the execute unit
package exec_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/exec_seq_core.sv
// rtl/exec_seq_core.sv - iterative 1-bit-per-cycle shifter and radix-2 shift-add multiplier
module exec_seq_core #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               mul,
    input  logic               left,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [WIDTH-1:0]   next_acc
);

    localparam int CNT_W = SHAMT_W + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             mul_q;
    logic             left_q;

    always_comb begin
        next_acc = acc;
        if (mul_q) begin
            next_acc = acc + (mplier[0] ? mcand : '0);
        end else if (left_q) begin
            next_acc = acc << 1;
        end else begin
            next_acc = acc >> 1;
        end
    end

    // done marks the final step: the owner captures next_acc on this same edge
    assign done = busy && (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
            mul_q  <= 1'b0;
            left_q <= 1'b0;
        end else if (load) begin
            busy   <= 1'b1;
            mul_q  <= mul;
            left_q <= left;
            mcand  <= a;
            mplier <= b;
            acc    <= mul ? '0 : a;
            count  <= mul ? CNT_W'(WIDTH) : {1'b0, shamt};
        end else if (busy) begin
            acc    <= next_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_alu_mc.sv
// rtl/exec_alu_mc.sv - multi-cycle execute unit with valid/ready handshake on both sides
module exec_alu_mc
    import exec_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf
);

    logic [1:0]         state;
    logic               accept;
    logic               go_busy;
    logic [SHAMT_W-1:0] shamt;
    logic               is_sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               core_done;
    logic [WIDTH-1:0]   core_acc;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = oper_B[SHAMT_W-1:0];
    assign go_busy   = (op == OP_MUL) || (is_shift(op) && (shamt != '0));

    // SUB reuses the adder as A + ~B + 1 so carry-out reads as "no borrow"
    always_comb begin
        is_sub    = (op == OP_SUB);
        b_eff     = is_sub ? ~oper_B : oper_B;
        sum       = {1'b0, oper_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_res   = oper_A;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (oper_A[WIDTH-1] == oper_B[WIDTH-1]) &&
                            (sum[WIDTH-1] != oper_A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (oper_A[WIDTH-1] != oper_B[WIDTH-1]) &&
                            (sum[WIDTH-1] != oper_A[WIDTH-1]);
            end
            OP_AND:  alu_res = oper_A & oper_B;
            OP_OR:   alu_res = oper_A | oper_B;
            OP_XOR:  alu_res = oper_A ^ oper_B;
            default: alu_res = oper_A;
        endcase
    end

    exec_seq_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_seq_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && go_busy),
        .mul      (op == OP_MUL),
        .left     (op == OP_SLL),
        .a        (oper_A),
        .b        (oper_B),
        .shamt    (shamt),
        .done     (core_done),
        .next_acc (core_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (go_busy) begin
                            state <= ST_BUSY;
                        end else begin
                            state      <= ST_DONE;
                            result     <= alu_res;
                            flag_zero  <= (alu_res == '0);
                            flag_carry <= alu_carry;
                            flag_ovf   <= alu_ovf;
                        end
                    end
                end
                ST_BUSY: begin
                    if (core_done) begin
                        state      <= ST_DONE;
                        result     <= core_acc;
                        flag_zero  <= (core_acc == '0);
                        flag_carry <= 1'b0;
                        flag_ovf   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_alu_mc.sv
// tb/tb_exec_alu_mc.sv - scoreboard bench for the multi-cycle execute unit
module tb_exec_alu_mc;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, MUL = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] oper_A;
    logic [31:0] oper_B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_ovf;

    int          tests = 0;
    int          fails = 0;
    logic [34:0] exp_q[$];
    logic [34:0] mon_exp;

    always #5 clk = ~clk;

    exec_alu_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .oper_A     (oper_A),
        .oper_B     (oper_B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h expected none",
                         {result, flag_zero, flag_carry, flag_ovf});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result_flags", {result, flag_zero, flag_carry, flag_ovf}, mon_exp);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 35'(in_ready), 35'(1));
        in_valid = 1'b1;
        op       = o;
        oper_A   = a;
        oper_B   = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        oper_A   = $urandom;
        oper_B   = $urandom;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(name, 35'(lat), 35'(exp_lat));
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic z,
                          input logic c, input logic v, input int lat);
        exp_q.push_back({r, z, c, v});
        issue(o, a, b);
        wait_out(name, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = ADD;
        oper_A    = '0;
        oper_B    = '0;
        out_ready = 1'b1;
        #12;
        chk("reset_in_ready", 35'(in_ready), 35'(1));
        chk("reset_out_valid", 35'(out_valid), 35'(0));
        chk("reset_result_flags", {result, flag_zero, flag_carry, flag_ovf}, 35'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_wrap_lat",  ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1, 0, 0);
        run_op("add_ovf_lat",   ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 1, 0);
        run_op("sub_ovf_lat",   SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1, 1, 0);
        run_op("sub_borrow_lat", SUB, 32'h3,         32'h5,         32'hFFFF_FFFE, 0, 0, 0, 0);
        run_op("and_lat",       AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0);
        run_op("or_lat",        OR_,  32'h0F0F_0000, 32'h0000_0F0F, 32'h0F0F_0F0F, 0, 0, 0, 0);
        run_op("xor_lat",       XOR_, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0,         1, 0, 0, 0);
        run_op("sll31_lat",     SLL,  32'h1,         32'h1F,        32'h8000_0000, 0, 0, 0, 31);
        run_op("srl0_lat",      SRL,  32'hF0,        32'h0,         32'hF0,        0, 0, 0, 0);
        run_op("srl4_lat",      SRL,  32'h8000_0000, 32'h24,        32'h0800_0000, 0, 0, 0, 4);
        run_op("mul_a_lat",     MUL,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 0, 0, 0, 32);
        run_op("mul_b_lat",     MUL,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 0, 0, 0, 32);

        // Backpressure: DONE held for 10 cycles with stray in_valid pulses
        out_ready = 1'b0;
        exp_q.push_back({32'd12, 1'b0, 1'b0, 1'b0});
        issue(ADD, 32'd5, 32'd7);
        wait_out("bp_lat", 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op       = XOR_;
            oper_A   = $urandom;
            oper_B   = $urandom;
            @(posedge clk); #1;
            chk("bp_hold", {result, flag_zero, flag_carry, flag_ovf}, {32'd12, 3'b000});
            chk("bp_in_ready", 35'(in_ready), 35'(0));
            chk("bp_out_valid", 35'(out_valid), 35'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 35'(out_valid), 35'(0));
        chk("bp_release_ready", 35'(in_ready), 35'(1));
        run_op("after_bp_lat", ADD, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0);

        // Reset in the middle of a multiply: nothing may come out
        issue(MUL, 32'h0001_0001, 32'h0001_0001);
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 35'(out_valid), 35'(0));
        chk("midrst_in_ready", 35'(in_ready), 35'(1));
        chk("midrst_result", {result, flag_zero, flag_carry, flag_ovf}, 35'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 35'(seen), 35'(0));
        run_op("post_rst_add_lat", ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 35'(exp_q.size()), 35'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
